// File: rtl/alu_pkg.sv
// Shared definitions for the FU<->ALU CSR responder: opcode values, FSM states,
// CSR bit positions and the state-to-CSR_ALU_OUT encoding.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SRA  = 4'h7;
    localparam logic [3:0] OP_SLT  = 4'h8;
    localparam logic [3:0] OP_SLTU = 4'h9;
    localparam logic [3:0] OP_MUL  = 4'hA;

    // CSR_ALU_OUT bit positions
    localparam int CSR_OP1_RDY = 0;
    localparam int CSR_OP2_RDY = 1;
    localparam int CSR_RES_VLD = 2;
    // CSR_ALU_IN bit positions
    localparam int CSR_PROTECT = 0;
    localparam int CSR_OP1_STB = 1;
    localparam int CSR_OP2_STB = 2;

    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        S_WAIT_OP1 = 2'd0,
        S_WAIT_OP2 = 2'd1,
        S_EXEC     = 2'd2,
        S_VALID    = 2'd3
    } state_t;

    function automatic logic [2:0] csr_encode(input state_t st);
        logic [2:0] enc;
        case (st)
            S_WAIT_OP1: enc = 3'b001;
            S_WAIT_OP2: enc = 3'b010;
            S_EXEC:     enc = 3'b000;
            S_VALID:    enc = 3'b100;
            default:    enc = 3'b001;
        endcase
        return enc;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU function f(aluop, a, b). Multiply exists only when
// ALU_MUL_EN is defined; otherwise opcode A yields zero.
module alu_core
    import alu_pkg::*;
#(
    parameter int DW  = 32,
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] i_aluop,
    input  logic [DW-1:0]  i_a,
    input  logic [DW-1:0]  i_b,
    output logic [DW-1:0]  o_y
);

    logic [4:0] w_shamt;

    assign w_shamt = i_b[4:0];

    // Result selection; unused opcodes B..F fall through to zero
    always_comb begin
        o_y = {DW{1'b0}};
        case (i_aluop)
            OP_ADD:  o_y = i_a + i_b;
            OP_SUB:  o_y = i_a - i_b;
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            OP_SLL:  o_y = i_a << w_shamt;
            OP_SRL:  o_y = i_a >> w_shamt;
            OP_SRA:  o_y = $signed(i_a) >>> w_shamt;
            OP_SLT:  o_y = {{(DW-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            OP_SLTU: o_y = {{(DW-1){1'b0}}, (i_a < i_b)};
`ifdef ALU_MUL_EN
            OP_MUL:  o_y = i_a * i_b;
`else
            OP_MUL:  o_y = {DW{1'b0}};
`endif
            default: o_y = {DW{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_csr_responder.sv
// Responder side of the FU<->ALU CSR handshake. Optional multiplier enabled by
// the ALU_MUL_EN macro (adds two cycles of latency to opcode A).
module alu_csr_responder
    import alu_pkg::*;
#(
    parameter int DW           = 32,
    parameter int OPW          = 4,
    parameter int EXEC_LATENCY = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DW-1:0]  OP1,
    input  logic [DW-1:0]  OP2,
    input  logic [OPW-1:0] ALUOP,
    input  logic [2:0]     CSR_ALU_IN,
    output logic [2:0]     CSR_ALU_OUT,
    output logic [DW-1:0]  OP3
);

    localparam logic [CNT_W-1:0] LAT_BASE = CNT_W'(EXEC_LATENCY - 1);
`ifdef ALU_MUL_EN
    localparam logic [CNT_W-1:0] LAT_MUL  = CNT_W'(EXEC_LATENCY + 1);
`endif

    state_t           r_state;
    state_t           w_state_next;
    logic [DW-1:0]    r_op1;
    logic [DW-1:0]    r_op2;
    logic [OPW-1:0]   r_aluop;
    logic [CNT_W-1:0] r_cnt;
    logic             r_prot_seen;
    logic [2:0]       r_csr_out;
    logic [DW-1:0]    r_op3;

    logic             w_op1_load;
    logic             w_op2_load;
    logic             w_exec_done;
    logic             w_release;
    logic [CNT_W-1:0] w_cnt_load;
    logic [2:0]       w_csr_cur;
    logic [DW-1:0]    w_alu_y;

    assign w_op1_load  = (r_state == S_WAIT_OP1) && CSR_ALU_IN[CSR_OP1_STB];
    assign w_op2_load  = (r_state == S_WAIT_OP2) && CSR_ALU_IN[CSR_OP2_STB];
    assign w_exec_done = (r_state == S_EXEC) && (r_cnt == {CNT_W{1'b0}});
    assign w_release   = (r_state == S_VALID) && r_prot_seen && !CSR_ALU_IN[CSR_PROTECT];

`ifdef ALU_MUL_EN
    assign w_cnt_load = (ALUOP == OP_MUL) ? LAT_MUL : LAT_BASE;
`else
    assign w_cnt_load = LAT_BASE;
`endif

    alu_core #(
        .DW  (DW),
        .OPW (OPW)
    ) u_core (
        .i_aluop (r_aluop),
        .i_a     (r_op1),
        .i_b     (r_op2),
        .o_y     (w_alu_y)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_WAIT_OP1;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_WAIT_OP1: begin
                if (w_op1_load) w_state_next = S_WAIT_OP2;
                else            w_state_next = S_WAIT_OP1;
            end
            S_WAIT_OP2: begin
                if (w_op2_load) w_state_next = S_EXEC;
                else            w_state_next = S_WAIT_OP2;
            end
            S_EXEC: begin
                if (w_exec_done) w_state_next = S_VALID;
                else             w_state_next = S_EXEC;
            end
            S_VALID: begin
                if (w_release) w_state_next = S_WAIT_OP1;
                else           w_state_next = S_VALID;
            end
            default: w_state_next = S_WAIT_OP1;
        endcase
    end

    // FSM output decode: CSR flags follow the current state one cycle later
    always_comb begin
        w_csr_cur = csr_encode(r_state);
    end

    // Registered CSR flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_csr_out <= 3'b001;
        end else begin
            r_csr_out <= w_csr_cur;
        end
    end

    // Operand capture, latency counter, protect tracking and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op1       <= {DW{1'b0}};
            r_op2       <= {DW{1'b0}};
            r_aluop     <= {OPW{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_prot_seen <= 1'b0;
            r_op3       <= {DW{1'b0}};
        end else begin
            if (w_op1_load) begin
                r_op1 <= OP1;
            end
            if (w_op2_load) begin
                r_op2   <= OP2;
                r_aluop <= ALUOP;
                r_cnt   <= w_cnt_load;
            end else if ((r_state == S_EXEC) && (r_cnt != {CNT_W{1'b0}})) begin
                r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (w_exec_done) begin
                r_op3 <= w_alu_y;
            end
            // prot_seen only means something while the result is being held
            if (w_release) begin
                r_prot_seen <= 1'b0;
            end else if ((r_state == S_VALID) && CSR_ALU_IN[CSR_PROTECT]) begin
                r_prot_seen <= 1'b1;
            end
        end
    end

    assign CSR_ALU_OUT = r_csr_out;
    assign OP3         = r_op3;

endmodule

// File: tb/tb_alu_csr_responder.sv
// Directed bench for alu_csr_responder: table-driven opcode vectors plus
// hand-written handshake/reset sequences. Honors ALU_MUL_EN like the RTL.
module tb_alu_csr_responder;

    localparam int DW  = 32;
    localparam int OPW = 4;
    localparam int LAT = 2;

    logic           clk;
    logic           rst;
    logic [DW-1:0]  OP1;
    logic [DW-1:0]  OP2;
    logic [OPW-1:0] ALUOP;
    logic [2:0]     CSR_ALU_IN;
    logic [2:0]     CSR_ALU_OUT;
    logic [DW-1:0]  OP3;

    int tests;
    int fails;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    alu_csr_responder #(
        .DW           (DW),
        .OPW          (OPW),
        .EXEC_LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .OP1         (OP1),
        .OP2         (OP2),
        .ALUOP       (ALUOP),
        .CSR_ALU_IN  (CSR_ALU_IN),
        .CSR_ALU_OUT (CSR_ALU_OUT),
        .OP3         (OP3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wait for result-valid; 'already' edges have elapsed since the OP2 strobe edge
    task automatic wait_valid(input string name, input int already, input int lat);
        int k;
        k = already;
        while (!CSR_ALU_OUT[2] && k < 40) begin
            tick();
            k++;
        end
        chk({name, " latency"}, 32'(k), 32'(lat + 1));
        chk({name, " out valid"}, {29'd0, CSR_ALU_OUT}, 32'h4);
    endtask

    task automatic start_op(input string name, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] y, input int lat);
        OP1 = a; CSR_ALU_IN = 3'b010;
        tick();
        OP2 = b; ALUOP = op; CSR_ALU_IN = 3'b100;
        tick();
        CSR_ALU_IN = 3'b000;
        chk({name, " op2 rdy"}, {29'd0, CSR_ALU_OUT}, 32'h2);
        wait_valid(name, 0, lat);
        chk({name, " result"}, OP3, y);
    endtask

    // Protect for one cycle, drop it, and confirm the responder re-arms holding OP3
    task automatic release_op(input string name, input logic [31:0] y);
        CSR_ALU_IN = 3'b001;
        tick();
        CSR_ALU_IN = 3'b000;
        tick();
        tick();
        chk({name, " rearm"}, {29'd0, CSR_ALU_OUT}, 32'h1);
        chk({name, " held"}, OP3, y);
    endtask

    initial begin
        logic [31:0] mul_y;
        int          mul_lat;
        tests = 0;
        fails = 0;
        rst = 1'b1; OP1 = '0; OP2 = '0; ALUOP = '0; CSR_ALU_IN = 3'b000;
`ifdef ALU_MUL_EN
        mul_y = 32'd42; mul_lat = LAT + 2;
`else
        mul_y = 32'd0;  mul_lat = LAT;
`endif
        vecs[0]  = '{4'h0, 32'd5,        32'd7,        32'd12,       LAT};
        vecs[1]  = '{4'h1, 32'd3,        32'd5,        32'hFFFFFFFE, LAT};
        vecs[2]  = '{4'h2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, LAT};
        vecs[3]  = '{4'h3, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, LAT};
        vecs[4]  = '{4'h4, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, LAT};
        vecs[5]  = '{4'h5, 32'h00000001, 32'h0000003F, 32'h80000000, LAT};
        vecs[6]  = '{4'h6, 32'h80000000, 32'd4,        32'h08000000, LAT};
        vecs[7]  = '{4'h7, 32'h80000000, 32'd4,        32'hF8000000, LAT};
        vecs[8]  = '{4'h8, 32'hFFFFFFFF, 32'd1,        32'd1,        LAT};
        vecs[9]  = '{4'h9, 32'hFFFFFFFF, 32'd1,        32'd0,        LAT};
        vecs[10] = '{4'hA, 32'd6,        32'd7,        mul_y,        mul_lat};
        vecs[11] = '{4'hB, 32'd3,        32'd4,        32'd0,        LAT};

        tick();
        tick();
        chk("reset out", {29'd0, CSR_ALU_OUT}, 32'h1);
        chk("reset op3", OP3, 32'h0);
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("idle out", {29'd0, CSR_ALU_OUT}, 32'h1);

        for (int i = 0; i < 12; i++) begin
            start_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                     vecs[i].y, vecs[i].lat);
            release_op($sformatf("vec%0d", i), vecs[i].y);
        end

        // Result held with no protect ever, then through a protected window
        start_op("prot", 4'h0, 32'd100, 32'd23, 32'd123, LAT);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("noprot hold", {29'd0, CSR_ALU_OUT}, 32'h4);
        end
        CSR_ALU_IN = 3'b001;
        for (int i = 0; i < 5; i++) begin
            OP1 = $urandom; OP2 = $urandom;
            tick();
            chk("prot op3", OP3, 32'd123);
            chk("prot out", {29'd0, CSR_ALU_OUT}, 32'h4);
        end
        CSR_ALU_IN = 3'b000;
        tick();
        tick();
        chk("prot rearm", {29'd0, CSR_ALU_OUT}, 32'h1);
        chk("prot held", OP3, 32'd123);

        // Stray strobes: OP2 strobe while waiting for OP1, OP1 strobe during execution
        OP2 = 32'd77; CSR_ALU_IN = 3'b100;
        tick();
        CSR_ALU_IN = 3'b000;
        tick();
        tick();
        chk("stray op2 out", {29'd0, CSR_ALU_OUT}, 32'h1);
        OP1 = 32'd100; OP2 = 32'd55; CSR_ALU_IN = 3'b110;
        tick();
        OP2 = 32'd1; ALUOP = 4'h1; CSR_ALU_IN = 3'b100;
        tick();
        chk("stray op2 rdy", {29'd0, CSR_ALU_OUT}, 32'h2);
        OP1 = 32'd999; CSR_ALU_IN = 3'b010;
        tick();
        CSR_ALU_IN = 3'b000;
        wait_valid("stray", 1, LAT);
        chk("stray result", OP3, 32'd99);
        release_op("stray", 32'd99);

        // Reset in the middle of execution abandons the operation
        OP1 = 32'd10; CSR_ALU_IN = 3'b010;
        tick();
        OP2 = 32'd3; ALUOP = 4'h0; CSR_ALU_IN = 3'b100;
        tick();
        CSR_ALU_IN = 3'b000;
        tick();
        rst = 1'b1;
        tick();
        chk("midrst out", {29'd0, CSR_ALU_OUT}, 32'h1);
        chk("midrst op3", OP3, 32'h0);
        rst = 1'b0;
        tick();
        tick();
        chk("midrst idle", {29'd0, CSR_ALU_OUT}, 32'h1);
        chk("midrst op3 kept", OP3, 32'h0);
        start_op("recover", 4'h4, 32'h0000FFFF, 32'h00FF00FF, 32'h00FFFF00, LAT);
        release_op("recover", 32'h00FFFF00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
